// File: rtl/matu_tile_scheduler.sv
// matu_tile_scheduler: walks an R x C tile job through load, fill, run and drain.
// Define TILE_SCHED_PERF_EN to build the busy/stall performance counters.
module matu_tile_scheduler #(
    parameter int TILE_CNT_W = 8,
    parameter int ADDR_W     = 16,
    parameter int H_STRIDE   = 27,
    parameter int V_STRIDE   = 9,
    parameter int O_STRIDE   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [TILE_CNT_W-1:0] i_num_row_tiles,
    input  logic [TILE_CNT_W-1:0] i_num_col_tiles,
    input  logic [ADDR_W-1:0]     i_h_base,
    input  logic [ADDR_W-1:0]     i_v_base,
    input  logic [ADDR_W-1:0]     i_o_base,
    output logic                  o_ibh_load_req,
    output logic [ADDR_W-1:0]     o_ibh_load_addr,
    input  logic                  i_ibh_load_ack,
    output logic                  o_ibv_load_req,
    output logic [ADDR_W-1:0]     o_ibv_load_addr,
    input  logic                  i_ibv_load_ack,
    input  logic                  i_ibh_data_in_done,
    input  logic                  i_ibv_data_in_done,
    input  logic                  i_ib_data_out,
    input  logic                  i_sa_is_idle,
    output logic                  o_ob_drain_req,
    output logic [ADDR_W-1:0]     o_ob_drain_addr,
    input  logic                  i_ob_drain_ack,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TILE_CNT_W-1:0] o_tile_row,
    output logic [TILE_CNT_W-1:0] o_tile_col,
    output logic [31:0]           o_perf_cycles,
    output logic [31:0]           o_perf_stall
);
    localparam logic [ADDR_W-1:0]     H_STEP = ADDR_W'(H_STRIDE);
    localparam logic [ADDR_W-1:0]     V_STEP = ADDR_W'(V_STRIDE);
    localparam logic [ADDR_W-1:0]     O_STEP = ADDR_W'(O_STRIDE);
    localparam logic [TILE_CNT_W-1:0] ONE    = TILE_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [TILE_CNT_W-1:0] rows_q, cols_q, row_q, col_q;
    logic [ADDR_W-1:0]     v_base_q, h_addr_q, v_addr_q, o_addr_q;
    logic                  h_req_q, v_req_q, d_req_q, done_q, first_q;
    logic                  start_ok, zero_job, load_fin, fill_go;
    logic                  drain_ack, last_col, last_row, busy;

    assign start_ok  = i_start && !i_abort;
    assign zero_job  = (i_num_row_tiles == '0) || (i_num_col_tiles == '0);
    assign load_fin  = (!h_req_q || i_ibh_load_ack) && (!v_req_q || i_ibv_load_ack);
    assign fill_go   = i_ib_data_out && i_ibh_data_in_done && i_ibv_data_in_done;
    assign drain_ack = d_req_q && i_ob_drain_ack;
    assign last_col  = col_q == cols_q - ONE;
    assign last_row  = row_q == rows_q - ONE;
    assign busy      = state_q != S_IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok && !zero_job) state_d = S_LOAD;
            S_LOAD:  if (load_fin) state_d = S_FILL;
            S_FILL:  if (fill_go) state_d = S_RUN;
            // first RUN cycle still sees the controller's stale idle level
            S_RUN:   if (!first_q && i_sa_is_idle) state_d = S_DRAIN;
            S_DRAIN: if (drain_ack) state_d = (last_col && last_row) ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
        if (busy && i_abort) state_d = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rows_q   <= '0;
            cols_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            v_base_q <= '0;
            h_addr_q <= '0;
            v_addr_q <= '0;
            o_addr_q <= '0;
            h_req_q  <= 1'b0;
            v_req_q  <= 1'b0;
            d_req_q  <= 1'b0;
            done_q   <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            first_q <= state_q != S_RUN;
            h_req_q <= (state_d == S_LOAD) &&
                       (state_q != S_LOAD || (h_req_q && !i_ibh_load_ack));
            v_req_q <= (state_d == S_LOAD) &&
                       (state_q != S_LOAD || (v_req_q && !i_ibv_load_ack));
            d_req_q <= state_d == S_DRAIN;
            done_q  <= (state_q == S_IDLE && start_ok && zero_job) ||
                       (state_q == S_DRAIN && state_d == S_IDLE && !i_abort);
            if (state_q == S_IDLE && start_ok && !zero_job) begin
                rows_q   <= i_num_row_tiles;
                cols_q   <= i_num_col_tiles;
                row_q    <= '0;
                col_q    <= '0;
                v_base_q <= i_v_base;
                h_addr_q <= i_h_base;
                v_addr_q <= i_v_base;
                o_addr_q <= i_o_base;
            end else if (state_q == S_DRAIN && state_d == S_LOAD) begin
                o_addr_q <= o_addr_q + O_STEP;
                if (last_col) begin
                    col_q    <= '0;
                    row_q    <= row_q + ONE;
                    v_addr_q <= v_base_q;
                    h_addr_q <= h_addr_q + H_STEP;
                end else begin
                    col_q    <= col_q + ONE;
                    v_addr_q <= v_addr_q + V_STEP;
                end
            end
        end
    end

    assign o_ibh_load_req  = h_req_q;
    assign o_ibh_load_addr = h_addr_q;
    assign o_ibv_load_req  = v_req_q;
    assign o_ibv_load_addr = v_addr_q;
    assign o_ob_drain_req  = d_req_q;
    assign o_ob_drain_addr = o_addr_q;
    assign o_busy          = busy;
    assign o_done          = done_q;
    assign o_tile_row      = row_q;
    assign o_tile_col      = col_q;

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] cyc_q, stall_q;
    logic        stall;

    assign stall = (state_q == S_LOAD && !load_fin) || (state_q == S_FILL) ||
                   (state_q == S_DRAIN && !drain_ack);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (state_q == S_IDLE && start_ok) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (busy && cyc_q != '1)    cyc_q   <= cyc_q + 32'd1;
            if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    assign o_perf_cycles = cyc_q;
    assign o_perf_stall  = stall_q;
`else
    assign o_perf_cycles = '0;
    assign o_perf_stall  = '0;
`endif

endmodule

// File: tb/tb_matu_tile_scheduler.sv
// tb_matu_tile_scheduler: directed jobs against a small load/compute/drain
// responder; expected addresses and indices are hand-computed tables.
module tb_matu_tile_scheduler;
    localparam int TW = 8;
    localparam int AW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [TW-1:0] i_num_row_tiles = '0;
    logic [TW-1:0] i_num_col_tiles = '0;
    logic [AW-1:0] i_h_base = '0;
    logic [AW-1:0] i_v_base = '0;
    logic [AW-1:0] i_o_base = '0;
    logic          o_ibh_load_req;
    logic [AW-1:0] o_ibh_load_addr;
    logic          i_ibh_load_ack = 1'b0;
    logic          o_ibv_load_req;
    logic [AW-1:0] o_ibv_load_addr;
    logic          i_ibv_load_ack = 1'b0;
    logic          i_ibh_data_in_done = 1'b0;
    logic          i_ibv_data_in_done = 1'b0;
    logic          i_ib_data_out = 1'b0;
    logic          i_sa_is_idle = 1'b1;
    logic          o_ob_drain_req;
    logic [AW-1:0] o_ob_drain_addr;
    logic          i_ob_drain_ack = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic [TW-1:0] o_tile_row;
    logic [TW-1:0] o_tile_col;
    logic [31:0]   o_perf_cycles;
    logic [31:0]   o_perf_stall;

    int checks = 0;
    int failures = 0;
    int done_cnt;
    int busy_cyc;
    int aborted;
    logic [4:0] act;

    logic [AW-1:0] h_log[$], v_log[$], o_log[$];
    logic [TW-1:0] r_log[$], c_log[$];
    logic [AW-1:0] eh[$], ev[$], eo[$];
    logic [TW-1:0] er[$], ec[$];

    matu_tile_scheduler dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_start            (i_start),
        .i_abort            (i_abort),
        .i_num_row_tiles    (i_num_row_tiles),
        .i_num_col_tiles    (i_num_col_tiles),
        .i_h_base           (i_h_base),
        .i_v_base           (i_v_base),
        .i_o_base           (i_o_base),
        .o_ibh_load_req     (o_ibh_load_req),
        .o_ibh_load_addr    (o_ibh_load_addr),
        .i_ibh_load_ack     (i_ibh_load_ack),
        .o_ibv_load_req     (o_ibv_load_req),
        .o_ibv_load_addr    (o_ibv_load_addr),
        .i_ibv_load_ack     (i_ibv_load_ack),
        .i_ibh_data_in_done (i_ibh_data_in_done),
        .i_ibv_data_in_done (i_ibv_data_in_done),
        .i_ib_data_out      (i_ib_data_out),
        .i_sa_is_idle       (i_sa_is_idle),
        .o_ob_drain_req     (o_ob_drain_req),
        .o_ob_drain_addr    (o_ob_drain_addr),
        .i_ob_drain_ack     (i_ob_drain_ack),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_tile_row         (o_tile_row),
        .o_tile_col         (o_tile_col),
        .o_perf_cycles      (o_perf_cycles),
        .o_perf_stall       (o_perf_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_logs(input string tag);
        chk({tag, "_ntiles"}, 64'(o_log.size()), 64'(eo.size()));
        chk({tag, "_nloads"}, 64'(h_log.size()), 64'(eh.size()));
        for (int k = 0; k < eo.size(); k++) begin
            chk($sformatf("%s_o%0d", tag, k), 64'(o_log[k]), 64'(eo[k]));
            chk($sformatf("%s_h%0d", tag, k), 64'(h_log[k]), 64'(eh[k]));
            chk($sformatf("%s_v%0d", tag, k), 64'(v_log[k]), 64'(ev[k]));
            chk($sformatf("%s_row%0d", tag, k), 64'(r_log[k]), 64'(er[k]));
            chk($sformatf("%s_col%0d", tag, k), 64'(c_log[k]), 64'(ec[k]));
        end
    endtask

    // One job: acks after the given delays, compute runs 3 cycles,
    // optional abort while computing tile abort_tile.
    task automatic run_job(input logic [TW-1:0] r, input logic [TW-1:0] c,
                           input logic [AW-1:0] hb, input logic [AW-1:0] vb,
                           input logic [AW-1:0] ob, input int h_dly,
                           input int v_dly, input int d_dly, input int abort_tile);
        int hc = 0;
        int vc = 0;
        int dc = 0;
        int ph = 0;
        int run = 0;
        int tiles = 0;
        int budget = 0;
        logic prev_busy = 1'b0;
        logic h_pend = 1'b0, v_pend = 1'b0, d_pend = 1'b0;
        logic h_ackd = 1'b0, v_ackd = 1'b0, d_ackd = 1'b0;
        logic [AW-1:0] h_a = '0, v_a = '0, d_a = '0;
        h_log.delete(); v_log.delete(); o_log.delete();
        r_log.delete(); c_log.delete();
        done_cnt = 0;
        busy_cyc = 0;
        aborted = 0;
        i_ibh_data_in_done = 1'b0;
        i_ibv_data_in_done = 1'b0;
        i_sa_is_idle = 1'b1;
        @(negedge i_clk);
        i_num_row_tiles = r;
        i_num_col_tiles = c;
        i_h_base = hb;
        i_v_base = vb;
        i_o_base = ob;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        while (budget < 600) begin
            budget++;
            if (o_busy) busy_cyc++;
            if (o_done) begin
                done_cnt++;
                chk("busy_falls_with_done", 64'({o_busy, prev_busy}), 64'(2'b01));
                break;
            end
            i_ibh_load_ack = 1'b0;
            i_ibv_load_ack = 1'b0;
            i_ob_drain_ack = 1'b0;
            i_ib_data_out  = 1'b0;
            if (h_ackd) begin
                chk("h_req_drop", 64'(o_ibh_load_req), 64'(0));
                i_ibh_data_in_done = 1'b1;
            end
            if (v_ackd) begin
                chk("v_req_drop", 64'(o_ibv_load_req), 64'(0));
                i_ibv_data_in_done = 1'b1;
            end
            if (d_ackd) chk("drain_req_drop", 64'(o_ob_drain_req), 64'(0));
            h_ackd = 1'b0;
            v_ackd = 1'b0;
            d_ackd = 1'b0;
            if (h_pend) chk("h_req_held", 64'(o_ibh_load_req), 64'(1));
            if (v_pend) chk("v_req_held", 64'(o_ibv_load_req), 64'(1));
            if (d_pend) chk("drain_req_held", 64'(o_ob_drain_req), 64'(1));
            if (o_ibh_load_req) begin
                if (!h_pend) begin
                    h_pend = 1'b1; h_a = o_ibh_load_addr; hc = 0;
                end else chk("h_addr_stable", 64'(o_ibh_load_addr), 64'(h_a));
                if (hc == h_dly) begin
                    i_ibh_load_ack = 1'b1; h_pend = 1'b0; h_ackd = 1'b1;
                    h_log.push_back(h_a);
                end else hc++;
            end
            if (o_ibv_load_req) begin
                if (!v_pend) begin
                    v_pend = 1'b1; v_a = o_ibv_load_addr; vc = 0;
                end else chk("v_addr_stable", 64'(o_ibv_load_addr), 64'(v_a));
                if (vc == v_dly) begin
                    i_ibv_load_ack = 1'b1; v_pend = 1'b0; v_ackd = 1'b1;
                    v_log.push_back(v_a);
                end else vc++;
            end
            if (o_ob_drain_req) begin
                if (!d_pend) begin
                    d_pend = 1'b1; d_a = o_ob_drain_addr; dc = 0;
                    chk("drain_after_run", 64'(ph), 64'(3));
                end else chk("o_addr_stable", 64'(o_ob_drain_addr), 64'(d_a));
                if (dc == d_dly) begin
                    i_ob_drain_ack = 1'b1; d_pend = 1'b0; d_ackd = 1'b1;
                    o_log.push_back(d_a);
                    r_log.push_back(o_tile_row);
                    c_log.push_back(o_tile_col);
                    ph = 0;
                    tiles++;
                end else dc++;
            end
            case (ph)
                0: if (i_ibh_data_in_done && i_ibv_data_in_done) begin
                    i_ib_data_out = 1'b1; ph = 1;
                end
                1: begin
                    i_ibh_data_in_done = 1'b0;
                    i_ibv_data_in_done = 1'b0;
                    run = 0;
                    ph = 2;
                end
                2: if (run < 3) begin
                    i_sa_is_idle = 1'b0; run++;
                end else begin
                    i_sa_is_idle = 1'b1; ph = 3;
                end
                default: ;
            endcase
            if (abort_tile == tiles && ph == 2 && run == 1) begin
                i_abort = 1'b1;
                @(negedge i_clk);
                i_abort = 1'b0;
                i_sa_is_idle = 1'b1;
                chk("abort_reqs", 64'({o_ibh_load_req, o_ibv_load_req, o_ob_drain_req}), 64'(0));
                chk("abort_busy", 64'(o_busy), 64'(0));
                chk("abort_tile_idx", 64'(o_tile_col), 64'(1));
                aborted = 1;
                break;
            end
            prev_busy = o_busy;
            @(negedge i_clk);
        end
        i_ibh_load_ack = 1'b0;
        i_ibv_load_ack = 1'b0;
        i_ob_drain_ack = 1'b0;
        i_ib_data_out = 1'b0;
        i_ibh_data_in_done = 1'b0;
        i_ibv_data_in_done = 1'b0;
        i_sa_is_idle = 1'b1;
        repeat (4) begin
            @(negedge i_clk);
            if (o_done) done_cnt++;
        end
        chk("done_count", 64'(done_cnt), (abort_tile >= 0) ? 64'(0) : 64'(1));
        chk("idle_after_job", 64'(o_busy), 64'(0));
    endtask

    initial begin
        #12;
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_reqs", 64'({o_ibh_load_req, o_ibv_load_req, o_ob_drain_req}), 64'(0));
        chk("rst_idx", 64'({o_tile_row, o_tile_col}), 64'(0));
        chk("rst_addrs", 64'({o_ibh_load_addr, o_ibv_load_addr, o_ob_drain_addr}), 64'(0));
        chk("rst_perf", 64'({o_perf_cycles, o_perf_stall}), 64'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_job(8'd1, 8'd1, 16'h0100, 16'h0200, 16'h0300, 1, 1, 1, -1);
        eh = '{16'h0100}; ev = '{16'h0200}; eo = '{16'h0300};
        er = '{8'd0}; ec = '{8'd0};
        chk_logs("single");

        run_job(8'd2, 8'd3, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, -1);
        eh = '{16'd0, 16'd0, 16'd0, 16'd27, 16'd27, 16'd27};
        ev = '{16'd0, 16'd9, 16'd18, 16'd0, 16'd9, 16'd18};
        eo = '{16'd0, 16'd3, 16'd6, 16'd9, 16'd12, 16'd15};
        er = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
        ec = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        chk_logs("r2c3");

        run_job(8'd1, 8'd1, 16'h0040, 16'h0050, 16'h0060, 1, 6, 0, -1);
        eh = '{16'h0040}; ev = '{16'h0050}; eo = '{16'h0060};
        er = '{8'd0}; ec = '{8'd0};
        chk_logs("late_v_ack");

        run_job(8'd1, 8'd2, 16'h0001, 16'hFFF8, 16'hFFFE, 0, 0, 2, -1);
        eh = '{16'h0001, 16'h0001}; ev = '{16'hFFF8, 16'h0001};
        eo = '{16'hFFFE, 16'h0001};
        er = '{8'd0, 8'd0}; ec = '{8'd0, 8'd1};
        chk_logs("wrap");

        run_job(8'd2, 8'd2, 16'h0010, 16'h0020, 16'h0030, 1, 1, 1, 1);
        chk("abort_reached", 64'(aborted), 64'(1));
        chk("abort_tiles_done", 64'(o_log.size()), 64'(1));
        run_job(8'd2, 8'd2, 16'h0010, 16'h0020, 16'h0030, 1, 2, 1, -1);
        eh = '{16'h0010, 16'h0010, 16'h002B, 16'h002B};
        ev = '{16'h0020, 16'h0029, 16'h0020, 16'h0029};
        eo = '{16'h0030, 16'h0033, 16'h0036, 16'h0039};
        er = '{8'd0, 8'd0, 8'd1, 8'd1}; ec = '{8'd0, 8'd1, 8'd0, 8'd1};
        chk_logs("restart");

        @(negedge i_clk);
        i_num_row_tiles = 8'd0;
        i_num_col_tiles = 8'd5;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("zero_done", 64'(o_done), 64'(1));
        chk("zero_busy", 64'(o_busy), 64'(0));
        act = '0;
        repeat (5) begin
            @(negedge i_clk);
            act |= {o_busy, o_done, o_ibh_load_req, o_ibv_load_req, o_ob_drain_req};
        end
        chk("zero_quiet", 64'(act), 64'(0));

        i_num_row_tiles = 8'd1;
        i_num_col_tiles = 8'd1;
        i_abort = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        i_start = 1'b0;
        chk("abort_beats_start_busy", 64'(o_busy), 64'(0));
        chk("abort_beats_start_req", 64'({o_ibh_load_req, o_ibv_load_req}), 64'(0));

        run_job(8'd1, 8'd1, 16'h0100, 16'h0200, 16'h0300, 4, 4, 4, -1);
`ifdef TILE_SCHED_PERF_EN
        chk("perf_stall_min", 64'(o_perf_stall >= 32'd8), 64'(1));
        chk("perf_cycles", 64'(o_perf_cycles), 64'(busy_cyc));
`else
        chk("perf_cycles_tied", 64'(o_perf_cycles), 64'(0));
        chk("perf_stall_tied", 64'(o_perf_stall), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
